// File: rtl/sig_pulse_gen_pkg.sv
// Shared encodings and default timing for the pulse regenerator.
// The state encoding 2'd3 is unused; the FSM recovers from it to IDLE.
package sig_pulse_gen_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HIGH = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam int DEF_HIGH_CYCLES = 4;
   localparam int DEF_GAP_CYCLES  = 2;
   localparam int DEF_MAX_PENDING = 3;
   localparam int DEF_CNT_W       = 8;
   localparam int DEF_PEND_W      = 2;

endpackage

// File: rtl/sig_pulse_gen_if.sv
// Trigger/clear inputs and pulse/status outputs of the pulse regenerator.
// The master drives requests; the slave (the generator) drives the pulse and status.
interface sig_pulse_gen_if #(
   parameter int PEND_W = 2
);
   logic              trig;
   logic              clr;
   logic              out;
   logic              busy;
   logic              done;
   logic [PEND_W-1:0] pending;
   logic              ovf;

   modport master (output trig, clr, input out, busy, done, pending, ovf);
   modport slave  (input trig, clr, output out, busy, done, pending, ovf);
endinterface

// File: rtl/sig_pulse_gen_phase_timer.sv
// Loadable down-counter that times one HIGH or GAP phase; a load takes effect on the next edge.
// The counter holds at zero until reloaded; zero_o reflects the registered count.
module sig_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sig_pulse_gen.sv
// Regenerates single-cycle triggers as HIGH_CYCLES-wide pulses separated by GAP_CYCLES of low;
// OUT rises on the edge that samples TRIG; triggers arriving mid-pulse are queued (saturating, OVF on drop).
module sig_pulse_gen
   import sig_pulse_gen_pkg::*;
#(
   parameter int HIGH_CYCLES = DEF_HIGH_CYCLES,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int MAX_PENDING = DEF_MAX_PENDING,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int PEND_W      = DEF_PEND_W
) (
   input  logic           clk,
   input  logic           rst_n,
   sig_pulse_gen_if.slave bus
);

   logic [1:0]        state_q, state_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              out_q, done_q;
   logic              tmr_load, tmr_zero;
   logic [CNT_W-1:0]  tmr_val;
   logic              req, deq, active;

   sig_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      req      = bus.trig & ~bus.clr;
      active   = (state_q == ST_HIGH) || (state_q == ST_GAP);
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      deq      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d  = ST_HIGH;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(HIGH_CYCLES - 1);
            end
         end
         ST_HIGH: begin
            if (tmr_zero) begin
               state_d  = ST_GAP;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(GAP_CYCLES - 1);
            end
         end
         ST_GAP: begin
            if (tmr_zero) begin
               // A same-edge TRIG can feed the dequeue even when the queue was empty.
               if (!bus.clr && ((pend_q != '0) || req)) begin
                  deq      = 1'b1;
                  state_d  = ST_HIGH;
                  tmr_load = 1'b1;
                  tmr_val  = CNT_W'(HIGH_CYCLES - 1);
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (bus.clr) begin
         pend_d = '0;
         ovf_d  = 1'b0;
      end else if (deq) begin
         if (!req) begin
            pend_d = pend_q - PEND_W'(1);
         end
      end else if (req && active) begin
         if (pend_q < PEND_W'(MAX_PENDING)) begin
            pend_d = pend_q + PEND_W'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         out_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         out_q   <= (state_d == ST_HIGH);
         done_q  <= (state_q == ST_HIGH) && (state_d == ST_GAP);
      end
   end

   assign bus.out     = out_q;
   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.done    = done_q;
   assign bus.pending = pend_q;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_sig_pulse_gen.sv
// Bench for sig_pulse_gen: directed scenarios plus random trigger/clear traffic,
// compared every cycle against a pulse-schedule model (pulse start time plus offset arithmetic).
module tb_sig_pulse_gen;
   import sig_pulse_gen_pkg::*;

   localparam int H    = 4;
   localparam int G    = 2;
   localparam int MAXP = 3;
   localparam int PW   = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   sig_pulse_gen_if #(.PEND_W(PW)) bus ();

   sig_pulse_gen #(
      .HIGH_CYCLES (H),
      .GAP_CYCLES  (G),
      .MAX_PENDING (MAXP),
      .CNT_W       (8),
      .PEND_W      (PW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #100 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Model: a pulse started at edge m_start is high for offsets 0..H-1, low for H..H+G-1,
   // and the queue decision is taken at offset H+G.
   int m_act   = 0;
   int m_start = 0;
   int m_pend  = 0;
   int m_ovf   = 0;
   int ecnt    = 0;

   bit prev_out = 1'b0;
   int rises[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s @edge %0d: got %0d expected %0d", tag, ecnt, obs, exp);
      end
   endtask

   task automatic model_edge(input bit t_in, input bit c_in);
      bit t;
      int off;
      int avail;
      t = t_in && !c_in;
      ecnt++;
      if (m_act == 0) begin
         if (t) begin
            m_act   = 1;
            m_start = ecnt;
         end
         if (c_in) m_ovf = 0;
      end else begin
         off = ecnt - m_start;
         if (off == H + G) begin
            avail = c_in ? 0 : m_pend + int'(t);
            if (avail > 0) begin
               m_start = ecnt;
               m_pend  = avail - 1;
            end else begin
               m_act  = 0;
               m_pend = 0;
            end
            if (c_in) m_ovf = 0;
         end else if (c_in) begin
            m_pend = 0;
            m_ovf  = 0;
         end else if (t) begin
            if (m_pend < MAXP) m_pend++;
            else m_ovf = 1;
         end
      end
   endtask

   task automatic check_all();
      int off;
      bit e_out, e_done;
      off    = ecnt - m_start;
      e_out  = (m_act != 0) && (off < H);
      e_done = (m_act != 0) && (off == H);
      chk("out",     32'(bus.out),     32'(e_out));
      chk("busy",    32'(bus.busy),    32'(m_act != 0));
      chk("done",    32'(bus.done),    32'(e_done));
      chk("pending", 32'(bus.pending), 32'(m_pend));
      chk("ovf",     32'(bus.ovf),     32'(m_ovf != 0));
   endtask

   task automatic cycle(input bit t, input bit c);
      bus.trig = t;
      bus.clr  = c;
      @(posedge clk);
      model_edge(t, c);
      @(negedge clk);
      check_all();
      if (bus.out && !prev_out) rises.push_back(ecnt);
      prev_out = bus.out;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
   endtask

   initial begin
      bus.trig = 1'b0;
      bus.clr  = 1'b0;
      #50;
      chk("rst_out",  32'(bus.out),     32'd0);
      chk("rst_busy", 32'(bus.busy),    32'd0);
      chk("rst_done", 32'(bus.done),    32'd0);
      chk("rst_pend", 32'(bus.pending), 32'd0);
      chk("rst_ovf",  32'(bus.ovf),     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Single request
      rises.delete();
      cycle(1'b1, 1'b0);
      idle(10);
      chk("t1_pulses", 32'(rises.size()), 32'd1);

      // Two requests, second queued
      rises.delete();
      cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      chk("t2_pend", 32'(bus.pending), 32'd1);
      idle(16);
      chk("t2_pulses", 32'(rises.size()), 32'd2);
      if (rises.size() == 2) chk("t2_spacing", 32'(rises[1] - rises[0]), 32'(H + G));

      // Held trigger overflows the queue
      rises.delete();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
      chk("t3_pend", 32'(bus.pending), 32'(MAXP));
      chk("t3_ovf",  32'(bus.ovf),     32'd1);
      idle(30);
      chk("t3_pulses", 32'(rises.size()), 32'd4);
      if (rises.size() == 4) begin
         for (int i = 1; i < 4; i++) chk("t3_spacing", 32'(rises[i] - rises[i-1]), 32'(H + G));
      end
      cycle(1'b0, 1'b1);

      // Trigger on the dequeue edge
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      idle(H + G - 2);
      cycle(1'b1, 1'b0);
      chk("t4_pend", 32'(bus.pending), 32'd1);
      chk("t4_out",  32'(bus.out),     32'd1);
      idle(20);

      // Clear together with trigger mid-HIGH
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
      idle(H + G - 4);
      cycle(1'b0, 1'b0);
      chk("t5_pend_pre", 32'(bus.pending), 32'd2);
      cycle(1'b1, 1'b1);
      chk("t5_pend", 32'(bus.pending), 32'd0);
      chk("t5_ovf",  32'(bus.ovf),     32'd0);
      chk("t5_out",  32'(bus.out),     32'd1);
      idle(12);

      // Asynchronous reset in the second HIGH cycle
      cycle(1'b1, 1'b0);
      bus.trig = 1'b1;
      @(posedge clk);
      model_edge(1'b1, 1'b0);
      #1;
      chk("t6_pre_pend", 32'(bus.pending), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_out",  32'(bus.out),     32'd0);
      chk("t6_busy", 32'(bus.busy),    32'd0);
      chk("t6_pend", 32'(bus.pending), 32'd0);
      chk("t6_ovf",  32'(bus.ovf),     32'd0);
      m_act    = 0;
      m_pend   = 0;
      m_ovf    = 0;
      prev_out = 1'b0;
      bus.trig = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rises.delete();
      idle(10);
      chk("t6_no_pulse", 32'(rises.size()), 32'd0);

      // Random traffic with varying trigger density
      for (int b = 0; b < 40; b++) begin
         int dens;
         dens = $urandom_range(60, 5);
         for (int i = 0; i < 50; i++) begin
            cycle($urandom_range(99) < dens, $urandom_range(99) < 2);
         end
      end
      idle(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/sig_pulse_gen.md
Name: sig_pulse_gen

Overview:
Consumer-side counterpart of the push-button conditioning block (CLK/PUSH -> SIG single-cycle pulse).
- Accepts single-cycle trigger pulses (SIG-style) and regenerates each one as a fixed-width output pulse, followed by a mandatory low gap.
- Requests arriving while a pulse is in progress are counted and replayed in order.
- Sits between the button/edge-detect stage and slow consumers (LEDs, stepper step inputs, external strobes).

Parameters:
- HIGH_CYCLES, default 4: output high time in CLK cycles; legal range >= 1.
- GAP_CYCLES, default 2: minimum low time between output pulses in CLK cycles; legal range >= 1.
- MAX_PENDING, default 3: depth of the queued-request counter; legal range >= 1.
- CNT_W, default 8: width of the internal phase timer; must hold max(HIGH_CYCLES, GAP_CYCLES).
- PEND_W, default 2: width of PENDING; must hold MAX_PENDING.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- TRIG  in  1  request; each cycle sampled high counts as one request.
- CLR  in  1  synchronous clear of PENDING and OVF.
- OUT  out  1  generated pulse, registered.
- BUSY  out  1  high whenever the state is not IDLE.
- DONE  out  1  one-cycle strobe in the first GAP cycle after each high phase.
- PENDING  out  PEND_W  number of queued requests.
- OVF  out  1  sticky flag: a request was dropped.

Behaviour:
Reset
- On RST_N low, asynchronously and regardless of the current phase: state=IDLE, timer=0, OUT=0, BUSY=0, DONE=0, PENDING=0, OVF=0.
- A reset mid-pulse drops OUT immediately.
- No pulse is emitted after release until a new TRIG arrives.

State machine: IDLE, HIGH, GAP
- IDLE: TRIG=1 and CLR=0 -> HIGH; timer loads HIGH_CYCLES-1; OUT=1 from the same edge.
  - Latency: OUT rises on the edge that samples TRIG (1 cycle).
- HIGH: OUT=1; timer decrements each cycle.
  - Timer=0 -> GAP; timer loads GAP_CYCLES-1; OUT=0; DONE=1 for that one cycle.
  - OUT is therefore high for exactly HIGH_CYCLES cycles.
- GAP: OUT=0; timer decrements each cycle. At timer=0:
  - if PENDING>0 (after this cycle's CLR/TRIG effects): -> HIGH, PENDING-1, timer loads HIGH_CYCLES-1.
  - else -> IDLE.
- Back-to-back queued pulses have period HIGH_CYCLES+GAP_CYCLES.

Queue rules
- TRIG=1 while in HIGH or GAP:
  - PENDING<MAX_PENDING: PENDING+1.
  - PENDING=MAX_PENDING: request dropped, OVF<=1. No wrap; PENDING saturates.
- TRIG at the GAP->HIGH dequeue edge: increment and decrement cancel; PENDING unchanged. No overflow is possible on that edge.
- TRIG in IDLE starts a pulse directly; PENDING is untouched.
- CLR=1: PENDING<=0 and OVF<=0 next edge.
  - CLR beats a simultaneous TRIG; that TRIG is ignored in every state.
  - An in-progress HIGH/GAP phase completes normally; no dequeue follows.
- OVF stays set until CLR or reset.
- A TRIG held high for N cycles counts as N requests. The upstream SIG is single-cycle by construction.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, HIGH=2'd1, GAP=2'd2) and default timing constants. Encoding 2'd3 is illegal and recovers to IDLE.
- One sub-module: sig_phase_timer, a loadable down-counter (CNT_W bits) with a load value input and a zero flag, used for both the HIGH and GAP phases.
- FSM, queue counter and flags stay in the top module.

Test Plan:
Defaults throughout; 200 ns CLK period.
1. Single request: TRIG high for one cycle sampled at 300 ns -> OUT high at 300 ns; OUT low at 1100 ns; DONE high during 1100–1300 ns; BUSY low from 1500 ns; PENDING=0 throughout.
2. Queued requests: TRIG at edges 300 ns and 700 ns -> PENDING=1 after 700 ns; second pulse rises at 1500 ns; OUT high 1500–2300 ns; PENDING=0; OVF=0.
3. Overflow: TRIG held high 5 cycles starting at the 300 ns edge -> first pulse plus PENDING saturating at 3; one request dropped, so OVF=1; exactly 4 pulses total, rising edges 1200 ns apart.
4. Simultaneous dequeue and TRIG: PENDING=1, TRIG on the final GAP edge -> PENDING stays 1; the next pulse starts on that edge.
5. CLR with TRIG: PENDING=2 and OVF=1, CLR and TRIG together mid-HIGH -> PENDING=0, OVF=0; the current pulse finishes with full HIGH_CYCLES; then IDLE.
6. Reset mid-pulse: RST_N low at 2 ns into the second HIGH cycle -> OUT, BUSY, PENDING and OVF go 0 immediately, before the next CLK edge; after release, no pulse until a new TRIG.
